// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control unit
package ctrl_pkg;

  // FSM states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_TRAP   = 3'd4;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Write-back select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // PC select
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_IMM   = 2'd2;

  // Trap causes
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_BUS     = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN   = 2'd2;

  localparam logic [2:0] FMT_WORD = 3'b010;

  // funct3 -> ALU op for OP / OP-IMM; alt selects SUB/SRA
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_dec.sv
// rtl/ctrl_dec.sv - combinational RV32I opcode/funct decode and legality check
// Ports:
//   instr       in  32  instruction register contents
//   alu_op      out 4   ALU operation
//   op_a_sel    out 1   0 rs1, 1 pc
//   op_b_sel    out 1   0 rs2, 1 imm
//   wb_sel      out 2   write-back source for register-writing classes
//   pc_sel      out 2   next-PC source for non-branch register-writing classes
//   is_branch   out 1   conditional branch
//   is_load     out 1   load
//   is_store    out 1   store
//   br_on_zero  out 1   branch taken when ALU zero flag is 1 (else when 0)
//   illegal     out 1   not a legal RV32I instruction
module ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        op_a_sel,
  output logic        op_b_sel,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_sel,
  output logic        is_branch,
  output logic        is_load,
  output logic        is_store,
  output logic        br_on_zero,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register/immediate fields do not affect control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    alu_op     = ALU_ADD;
    op_a_sel   = 1'b0;
    op_b_sel   = 1'b0;
    wb_sel     = WB_ALU;
    pc_sel     = PC_PLUS4;
    is_branch  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    br_on_zero = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op = alu_from_funct3(funct3, funct7[5]);
        if (funct7 != 7'h00 &&
            !(funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        op_b_sel = 1'b1;
        // Only shifts borrow funct7; for the rest those bits are immediate.
        alu_op = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
        if (funct3 == 3'b001 && funct7 != 7'h00)
          illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
          illegal = 1'b1;
      end
      OPC_LUI: begin
        op_b_sel = 1'b1;
        wb_sel   = WB_IMM;
      end
      OPC_AUIPC: begin
        op_a_sel = 1'b1;
        op_b_sel = 1'b1;
      end
      OPC_JAL: begin
        op_a_sel = 1'b1;
        op_b_sel = 1'b1;
        wb_sel   = WB_PC4;
        pc_sel   = PC_IMM;
      end
      OPC_JALR: begin
        op_b_sel = 1'b1;
        wb_sel   = WB_PC4;
        pc_sel   = PC_ALU;
        illegal  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
        // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero.
        br_on_zero = funct3[0] ~^ funct3[2];
      end
      OPC_LOAD: begin
        is_load  = 1'b1;
        op_b_sel = 1'b1;
        illegal  = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      end
      OPC_STORE: begin
        is_store = 1'b1;
        op_b_sel = 1'b1;
        illegal  = (funct3 > 3'b010);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_mc.sv
// rtl/ctrl_mc.sv - multi-cycle RV32I control FSM with bus timeout and trap handling
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_instr[31:0]         instruction register (valid from DECODE)
//   i_alu_zf              ALU zero flag
//   i_addr_lo[1:0]        effective address low bits
//   i_bus_ack, i_bus_err  bus handshake; error only meaningful with ack
//   o_alu_op_a_sel, o_alu_op_b_sel, o_alu_op[3:0]   ALU controls
//   o_reg_w_en, o_reg_wb_sel[1:0]                   register write-back
//   o_bus_fmt[2:0], o_bus_ifetch, o_bus_r_en, o_bus_w_en   bus request
//   o_ir_w_en, o_pc_w_en, o_pc_sel[1:0]             IR/PC update
//   o_trap, o_trap_cause[1:0]                       halted and why
module ctrl_mc
  import ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_alu_zf,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  output logic        o_alu_op_a_sel,
  output logic        o_alu_op_b_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_reg_w_en,
  output logic [1:0]  o_reg_wb_sel,
  output logic [2:0]  o_bus_fmt,
  output logic        o_bus_ifetch,
  output logic        o_bus_r_en,
  output logic        o_bus_w_en,
  output logic        o_ir_w_en,
  output logic        o_pc_w_en,
  output logic [1:0]  o_pc_sel,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  localparam logic [15:0] WAIT_LAST = 16'(BUS_TIMEOUT - 1);

  logic [2:0]  state, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] wait_cnt;

  logic [3:0]  dec_alu_op;
  logic        dec_a_sel, dec_b_sel;
  logic [1:0]  dec_wb_sel, dec_pc_sel;
  logic        dec_branch, dec_load, dec_store, dec_br_on_zero, dec_illegal;

  logic [2:0]  funct3;
  logic        in_bus_state, bus_ok, bus_fail, timed_out, misaligned;

  ctrl_dec u_dec (
    .instr      (i_instr),
    .alu_op     (dec_alu_op),
    .op_a_sel   (dec_a_sel),
    .op_b_sel   (dec_b_sel),
    .wb_sel     (dec_wb_sel),
    .pc_sel     (dec_pc_sel),
    .is_branch  (dec_branch),
    .is_load    (dec_load),
    .is_store   (dec_store),
    .br_on_zero (dec_br_on_zero),
    .illegal    (dec_illegal)
  );

  assign funct3       = i_instr[14:12];
  assign in_bus_state = (state == ST_FETCH) || (state == ST_MEM);
  assign bus_ok       = i_bus_ack && !i_bus_err;
  assign bus_fail     = i_bus_ack && i_bus_err;
  // Fires on the BUS_TIMEOUT-th un-acked request cycle; an ack that cycle wins.
  assign timed_out    = (BUS_TIMEOUT != 0) && !i_bus_ack && (wait_cnt == WAIT_LAST);
  assign misaligned   = CHECK_ALIGN &&
                        ((funct3[1:0] == 2'b01 && i_addr_lo[0]) ||
                         (funct3[1:0] == 2'b10 && i_addr_lo != 2'b00));

  always_comb begin
    state_d = state;
    cause_d = cause_q;
    case (state)
      ST_FETCH: begin
        if (bus_ok) begin
          state_d = ST_DECODE;
        end else if (bus_fail || timed_out) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_load || dec_store) begin
          if (misaligned) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ALIGN;
          end else begin
            state_d = ST_MEM;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (bus_ok) begin
          state_d = ST_FETCH;
        end else if (bus_fail || timed_out) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_FETCH;
      cause_q  <= CAUSE_ILLEGAL;
      wait_cnt <= '0;
    end else begin
      state   <= state_d;
      cause_q <= cause_d;
      // Outside FETCH/MEM or on ack the counter sits at zero, so each
      // new bus phase starts counting from zero.
      if (in_bus_state && !i_bus_ack && BUS_TIMEOUT != 0)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
    end
  end

  // Outputs are forced low while i_rst is high so that a pending bus
  // request drops in the reset cycle itself.
  always_comb begin
    o_alu_op_a_sel = 1'b0;
    o_alu_op_b_sel = 1'b0;
    o_alu_op       = ALU_ADD;
    o_reg_w_en     = 1'b0;
    o_reg_wb_sel   = WB_ALU;
    o_bus_fmt      = 3'b000;
    o_bus_ifetch   = 1'b0;
    o_bus_r_en     = 1'b0;
    o_bus_w_en     = 1'b0;
    o_ir_w_en      = 1'b0;
    o_pc_w_en      = 1'b0;
    o_pc_sel       = PC_PLUS4;
    o_trap         = 1'b0;
    o_trap_cause   = 2'b00;
    if (!i_rst) begin
      case (state)
        ST_FETCH: begin
          o_bus_r_en   = 1'b1;
          o_bus_ifetch = 1'b1;
          o_bus_fmt    = FMT_WORD;
          o_ir_w_en    = bus_ok;
        end
        ST_EXEC: begin
          o_alu_op_a_sel = dec_a_sel;
          o_alu_op_b_sel = dec_b_sel;
          o_alu_op       = dec_alu_op;
          if (dec_branch) begin
            o_pc_w_en = 1'b1;
            o_pc_sel  = (i_alu_zf == dec_br_on_zero) ? PC_IMM : PC_PLUS4;
          end else if (!dec_load && !dec_store) begin
            o_reg_w_en   = 1'b1;
            o_reg_wb_sel = dec_wb_sel;
            o_pc_w_en    = 1'b1;
            o_pc_sel     = dec_pc_sel;
          end
        end
        ST_MEM: begin
          o_alu_op_b_sel = 1'b1;
          o_bus_fmt      = funct3;
          o_bus_r_en     = dec_load;
          o_bus_w_en     = dec_store;
          o_reg_wb_sel   = dec_load ? WB_MEM : WB_ALU;
          o_reg_w_en     = dec_load && bus_ok;
          o_pc_w_en      = bus_ok;
        end
        ST_TRAP: begin
          o_trap       = 1'b1;
          o_trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// tb/tb_ctrl_mc.sv - self-checking bench for ctrl_mc against an ISA-table reference model
module tb_ctrl_mc;

  localparam int TMO = 4;
  localparam int NEVER = 99;

  // Instruction classes of the reference table
  localparam logic [1:0] C_REG = 2'd0, C_BR = 2'd1, C_LD = 2'd2, C_ST = 2'd3;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                         A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9;
  localparam logic [31:0] M7 = 32'h0000007F, M10 = 32'h0000707F, M17 = 32'hFE00707F;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [1:0]  cls;
    logic [3:0]  op;
    logic        a;
    logic        b;
    logic [1:0]  wb;
    logic [1:0]  pcs;
    logic        tz;
    logic [1:0]  sz;
  } ent_t;

  typedef struct packed {
    logic       a;
    logic       b;
    logic [3:0] op;
    logic       rw;
    logic [1:0] wb;
    logic [2:0] fmt;
    logic       ifet;
    logic       re;
    logic       we;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       trap;
    logic [1:0] cause;
  } outs_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instr;
  logic        i_alu_zf;
  logic [1:0]  i_addr_lo;
  logic        i_bus_ack;
  logic        i_bus_err;
  logic        o_alu_op_a_sel, o_alu_op_b_sel, o_reg_w_en, o_bus_ifetch, o_bus_r_en, o_bus_w_en;
  logic        o_ir_w_en, o_pc_w_en, o_trap;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_reg_wb_sel, o_pc_sel, o_trap_cause;
  logic [2:0]  o_bus_fmt;
  outs_t       obs;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t tbl[$];

  ctrl_mc #(.BUS_TIMEOUT(TMO), .CHECK_ALIGN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_alu_zf(i_alu_zf),
    .i_addr_lo(i_addr_lo), .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err),
    .o_alu_op_a_sel(o_alu_op_a_sel), .o_alu_op_b_sel(o_alu_op_b_sel), .o_alu_op(o_alu_op),
    .o_reg_w_en(o_reg_w_en), .o_reg_wb_sel(o_reg_wb_sel), .o_bus_fmt(o_bus_fmt),
    .o_bus_ifetch(o_bus_ifetch), .o_bus_r_en(o_bus_r_en), .o_bus_w_en(o_bus_w_en),
    .o_ir_w_en(o_ir_w_en), .o_pc_w_en(o_pc_w_en), .o_pc_sel(o_pc_sel),
    .o_trap(o_trap), .o_trap_cause(o_trap_cause)
  );

  assign obs = {o_alu_op_a_sel, o_alu_op_b_sel, o_alu_op, o_reg_w_en, o_reg_wb_sel, o_bus_fmt,
                o_bus_ifetch, o_bus_r_en, o_bus_w_en, o_ir_w_en, o_pc_w_en, o_pc_sel,
                o_trap, o_trap_cause};

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic ent_t mk(input logic [31:0] mask, input logic [31:0] match, input logic [1:0] cls,
                              input logic [3:0] op, input logic a, input logic b, input logic [1:0] wb,
                              input logic [1:0] pcs, input logic tz, input logic [1:0] sz);
    ent_t e;
    e = '{mask, match, cls, op, a, b, wb, pcs, tz, sz};
    return e;
  endfunction

  task automatic build_table();
    tbl.push_back(mk(M7,  32'h00000037, C_REG, A_ADD,  0, 1, 3, 0, 0, 0)); // LUI
    tbl.push_back(mk(M7,  32'h00000017, C_REG, A_ADD,  1, 1, 0, 0, 0, 0)); // AUIPC
    tbl.push_back(mk(M7,  32'h0000006F, C_REG, A_ADD,  1, 1, 2, 2, 0, 0)); // JAL
    tbl.push_back(mk(M10, 32'h00000067, C_REG, A_ADD,  0, 1, 2, 1, 0, 0)); // JALR
    tbl.push_back(mk(M10, 32'h00000063, C_BR,  A_SUB,  0, 0, 0, 0, 1, 0)); // BEQ
    tbl.push_back(mk(M10, 32'h00001063, C_BR,  A_SUB,  0, 0, 0, 0, 0, 0)); // BNE
    tbl.push_back(mk(M10, 32'h00004063, C_BR,  A_SLT,  0, 0, 0, 0, 0, 0)); // BLT
    tbl.push_back(mk(M10, 32'h00005063, C_BR,  A_SLT,  0, 0, 0, 0, 1, 0)); // BGE
    tbl.push_back(mk(M10, 32'h00006063, C_BR,  A_SLTU, 0, 0, 0, 0, 0, 0)); // BLTU
    tbl.push_back(mk(M10, 32'h00007063, C_BR,  A_SLTU, 0, 0, 0, 0, 1, 0)); // BGEU
    tbl.push_back(mk(M10, 32'h00000003, C_LD,  A_ADD,  0, 1, 0, 0, 0, 0)); // LB
    tbl.push_back(mk(M10, 32'h00001003, C_LD,  A_ADD,  0, 1, 0, 0, 0, 1)); // LH
    tbl.push_back(mk(M10, 32'h00002003, C_LD,  A_ADD,  0, 1, 0, 0, 0, 2)); // LW
    tbl.push_back(mk(M10, 32'h00004003, C_LD,  A_ADD,  0, 1, 0, 0, 0, 0)); // LBU
    tbl.push_back(mk(M10, 32'h00005003, C_LD,  A_ADD,  0, 1, 0, 0, 0, 1)); // LHU
    tbl.push_back(mk(M10, 32'h00000023, C_ST,  A_ADD,  0, 1, 0, 0, 0, 0)); // SB
    tbl.push_back(mk(M10, 32'h00001023, C_ST,  A_ADD,  0, 1, 0, 0, 0, 1)); // SH
    tbl.push_back(mk(M10, 32'h00002023, C_ST,  A_ADD,  0, 1, 0, 0, 0, 2)); // SW
    tbl.push_back(mk(M10, 32'h00000013, C_REG, A_ADD,  0, 1, 0, 0, 0, 0)); // ADDI
    tbl.push_back(mk(M10, 32'h00002013, C_REG, A_SLT,  0, 1, 0, 0, 0, 0)); // SLTI
    tbl.push_back(mk(M10, 32'h00003013, C_REG, A_SLTU, 0, 1, 0, 0, 0, 0)); // SLTIU
    tbl.push_back(mk(M10, 32'h00004013, C_REG, A_XOR,  0, 1, 0, 0, 0, 0)); // XORI
    tbl.push_back(mk(M10, 32'h00006013, C_REG, A_OR,   0, 1, 0, 0, 0, 0)); // ORI
    tbl.push_back(mk(M10, 32'h00007013, C_REG, A_AND,  0, 1, 0, 0, 0, 0)); // ANDI
    tbl.push_back(mk(M17, 32'h00001013, C_REG, A_SLL,  0, 1, 0, 0, 0, 0)); // SLLI
    tbl.push_back(mk(M17, 32'h00005013, C_REG, A_SRL,  0, 1, 0, 0, 0, 0)); // SRLI
    tbl.push_back(mk(M17, 32'h40005013, C_REG, A_SRA,  0, 1, 0, 0, 0, 0)); // SRAI
    tbl.push_back(mk(M17, 32'h00000033, C_REG, A_ADD,  0, 0, 0, 0, 0, 0)); // ADD
    tbl.push_back(mk(M17, 32'h40000033, C_REG, A_SUB,  0, 0, 0, 0, 0, 0)); // SUB
    tbl.push_back(mk(M17, 32'h00001033, C_REG, A_SLL,  0, 0, 0, 0, 0, 0)); // SLL
    tbl.push_back(mk(M17, 32'h00002033, C_REG, A_SLT,  0, 0, 0, 0, 0, 0)); // SLT
    tbl.push_back(mk(M17, 32'h00003033, C_REG, A_SLTU, 0, 0, 0, 0, 0, 0)); // SLTU
    tbl.push_back(mk(M17, 32'h00004033, C_REG, A_XOR,  0, 0, 0, 0, 0, 0)); // XOR
    tbl.push_back(mk(M17, 32'h00005033, C_REG, A_SRL,  0, 0, 0, 0, 0, 0)); // SRL
    tbl.push_back(mk(M17, 32'h40005033, C_REG, A_SRA,  0, 0, 0, 0, 0, 0)); // SRA
    tbl.push_back(mk(M17, 32'h00006033, C_REG, A_OR,   0, 0, 0, 0, 0, 0)); // OR
    tbl.push_back(mk(M17, 32'h00007033, C_REG, A_AND,  0, 0, 0, 0, 0, 0)); // AND
  endtask

  function automatic int find(input logic [31:0] ins);
    for (int i = 0; i < tbl.size(); i++)
      if ((ins & tbl[i].mask) == tbl[i].match) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_instr();
    int i;
    if ($urandom_range(0, 3) == 0) return $urandom();
    i = $urandom_range(0, tbl.size() - 1);
    return ($urandom() & ~tbl[i].mask) | tbl[i].match;
  endfunction

  task automatic next();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input outs_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic noise();
    i_bus_ack = 1'($urandom());
    i_bus_err = 1'($urandom());
    i_alu_zf  = 1'($urandom());
    i_addr_lo = 2'($urandom());
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    noise();
    #1;
    chk(tag, '0);
    next();
    i_rst = 1'b0;
  endtask

  task automatic trap_phase(input logic [1:0] cz);
    outs_t e;
    e = '0;
    e.trap  = 1'b1;
    e.cause = cz;
    for (int k = 0; k < 3; k++) begin
      noise();
      i_instr = $urandom();
      #1;
      chk("trap", e);
      next();
    end
    do_reset("trap_rst");
  endtask

  // One instruction from the first fetch cycle until the core is back in
  // FETCH (possibly through a trap and reset). fw/mw: wait cycles before ack
  // (NEVER = no ack). rst_mem: MEM cycle index at which reset hits, -1 none.
  task automatic run(input logic [31:0] ins, input int fw, input bit ferr, input int mw,
                     input bit merr, input logic zf, input logic [1:0] alo, input int rst_mem);
    outs_t e;
    ent_t  t;
    int    idx;
    bit    done;
    bit    mis;

    done = 0;
    for (int k = 0; !done; k++) begin
      noise();
      i_instr   = $urandom();
      i_bus_ack = (k == fw);
      if (i_bus_ack) i_bus_err = ferr;
      #1;
      e = '0;
      e.re = 1'b1; e.ifet = 1'b1; e.fmt = 3'b010;
      e.irw = (k == fw) && !ferr;
      chk("fetch", e);
      next();
      if (k == fw) begin
        done = 1;
        if (ferr) begin trap_phase(2'd1); return; end
      end else if (k == TMO - 1) begin
        trap_phase(2'd1);
        return;
      end
    end

    i_instr = ins;
    noise();
    #1;
    chk("decode", '0);
    next();
    idx = find(ins);
    if (idx < 0) begin trap_phase(2'd0); return; end
    t = tbl[idx];

    noise();
    i_alu_zf  = zf;
    i_addr_lo = alo;
    #1;
    e = '0;
    e.a = t.a; e.b = t.b; e.op = t.op;
    mis = (t.sz == 2'd1 && alo[0]) || (t.sz == 2'd2 && alo != 2'b00);
    if (t.cls == C_REG) begin
      e.rw = 1'b1; e.wb = t.wb; e.pcw = 1'b1; e.pcs = t.pcs;
    end else if (t.cls == C_BR) begin
      e.pcw = 1'b1;
      e.pcs = (zf == t.tz) ? 2'd2 : 2'd0;
    end
    chk("exec", e);
    next();
    if (t.cls == C_REG || t.cls == C_BR) return;
    if (mis) begin trap_phase(2'd2); return; end

    done = 0;
    for (int k = 0; !done; k++) begin
      noise();
      if (k == rst_mem) begin
        i_bus_ack = 1'b0;
        do_reset("rst_mem");
        return;
      end
      i_bus_ack = (k == mw);
      if (i_bus_ack) i_bus_err = merr;
      #1;
      e = '0;
      e.b = 1'b1; e.op = A_ADD; e.fmt = ins[14:12];
      e.re = (t.cls == C_LD); e.we = (t.cls == C_ST);
      e.wb = (t.cls == C_LD) ? 2'd1 : 2'd0;
      if (k == mw && !merr) begin
        e.rw = (t.cls == C_LD);
        e.pcw = 1'b1;
      end
      chk("mem", e);
      next();
      if (k == mw) begin
        done = 1;
        if (merr) begin trap_phase(2'd1); return; end
      end else if (k == TMO - 1) begin
        trap_phase(2'd1);
        return;
      end
    end
  endtask

  initial begin
    int fw, mw, rm;
    bit fe, me;
    build_table();
    i_rst = 1'b1;
    i_instr = '0;
    noise();
    next();
    do_reset("reset");

    run(32'h00500093, 0, 0, 0, 0, 1'b0, 2'b00, -1);     // ADDI x1,x0,5
    run(32'h00000063, 0, 0, 0, 0, 1'b1, 2'b00, -1);     // BEQ taken
    run(32'h00000063, 1, 0, 0, 0, 1'b0, 2'b00, -1);     // BEQ not taken
    run(32'h0000A103, 0, 0, 3, 0, 1'b0, 2'b00, -1);     // LW, 3 waits
    run(32'h0020A023, 0, 0, 0, 0, 1'b0, 2'b10, -1);     // SW misaligned
    run(32'h00000013, NEVER, 0, 0, 0, 1'b0, 2'b00, -1); // fetch timeout
    run(32'h00000000, 0, 0, 0, 0, 1'b0, 2'b00, -1);     // illegal
    run(32'h0000A103, 0, 0, NEVER, 0, 1'b0, 2'b00, 1);  // reset mid MEM wait
    run(32'h00001103, 2, 1, 0, 0, 1'b0, 2'b00, -1);     // fetch bus error
    run(32'h00001103, 0, 0, 1, 1, 1'b0, 2'b00, -1);     // LH mem bus error
    run(32'h00001103, 0, 0, 0, 0, 1'b0, 2'b01, -1);     // LH misaligned
    run(32'h00001023, 0, 0, 2, 0, 1'b0, 2'b10, -1);     // SH aligned
    run(32'h00000003, 0, 0, 0, 0, 1'b0, 2'b11, -1);     // LB any offset
    run(32'h0000A023, 0, 0, NEVER, 0, 1'b0, 2'b00, -1); // SW mem timeout
    run(32'h02000033, 0, 0, 0, 0, 1'b0, 2'b00, -1);     // funct7 01 illegal
    run(32'h40001033, 0, 0, 0, 0, 1'b0, 2'b00, -1);     // SUB-style SLL illegal

    for (int n = 0; n < 300; n++) begin
      fw = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
      fe = ($urandom_range(0, 15) == 0);
      me = ($urandom_range(0, 15) == 0);
      rm = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 2) : -1;
      run(rand_instr(), fw, fe, mw, me, 1'($urandom()), 2'($urandom()), rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_mc.md
# ctrl_mc

Multi-cycle RV32I control unit with illegal-instruction, bus-error and misalignment traps. It replaces the single-cycle combinational decoder and sequences each instruction through fetch, decode, execute and memory states. It drives the same datapath controls (ALU operand selects, ALU op, register write, write-back select, bus format/enables, PC select), plus instruction-register and PC write strobes. It sits between the shared instruction/data bus and the existing datapath, and tolerates variable bus latency through an ack handshake.

## Interface
- BUS_TIMEOUT, 16: max wait cycles for i_bus_ack; 0 disables the timeout.
- CHECK_ALIGN, 1: 1 traps misaligned LH/LHU/LW/SH/SW; 0 passes them to the bus.
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_instr  in  32  instruction register contents (valid from DECODE onward).
- i_alu_zf  in  1  ALU zero flag of current EXEC result.
- i_addr_lo  in  2  ALU result bits [1:0] (effective address low bits).
- i_bus_ack  in  1  bus transfer complete this cycle.
- i_bus_err  in  1  bus error; sampled only together with i_bus_ack.
- o_alu_op_a_sel  out  1  0 rs1, 1 pc.
- o_alu_op_b_sel  out  1  0 rs2, 1 imm.
- o_alu_op  out  4  ALU operation (package encoding).
- o_reg_w_en  out  1  register file write strobe.
- o_reg_wb_sel  out  2  0 alu, 1 mem, 2 pc+4, 3 imm.
- o_bus_fmt  out  3  funct3 of load/store; 3'b010 during fetch.
- o_bus_ifetch  out  1  bus address = pc (fetch) instead of ALU result.
- o_bus_r_en / o_bus_w_en  out  1 each  bus request, held until ack.
- o_ir_w_en  out  1  latch bus read data into instruction register.
- o_pc_w_en  out  1  PC update strobe.
- o_pc_sel  out  2  0 pc+4, 1 alu res, 2 pc+imm.
- o_trap  out  1  sticky; core halted.
- o_trap_cause  out  2  0 illegal, 1 bus error/timeout, 2 misaligned.

## Operation
- States: FETCH, DECODE, EXEC, MEM, TRAP. Reset → FETCH, wait counter 0, all outputs 0.
- FETCH: o_bus_r_en=1, o_bus_ifetch=1, fmt 010. On ack without error: o_ir_w_en=1 → DECODE. On ack with error, or on timeout: → TRAP, cause 1.
- DECODE: full RV32I legality check. Illegal if any of:
  - instr[1:0]≠11, or opcode unknown;
  - OP funct7 ∉ {00,20}, or 20 used with funct3 other than 000/101;
  - OP-IMM shift funct7 illegal;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >010;
  - JALR funct3≠000.
  - Illegal → TRAP, cause 0; otherwise → EXEC. No enables asserted.
- EXEC: ALU selects/op exactly as the single-cycle decode (loads/stores/JAL/JALR/AUIPC = ADD; branches SUB/SLT/SLTU).
  - ALU, LUI, AUIPC, JAL, JALR: o_reg_w_en=1 plus o_pc_w_en=1 with the matching pc_sel → FETCH.
  - Branch: o_pc_w_en=1; pc_sel=2 when the condition holds (BEQ zf=1, BNE zf=0, BLT/BLTU zf=0, BGE/BGEU zf=1), else 0 → FETCH.
  - Load/store: if CHECK_ALIGN and misaligned (halfword: i_addr_lo[0]; word: i_addr_lo≠0) → TRAP, cause 2; else → MEM.
- MEM: ALU held at ADD, rs1/imm selected. o_bus_r_en (load) or o_bus_w_en (store), fmt=funct3. On ack without error: load sets o_reg_w_en=1, wb_sel=1; both set o_pc_w_en=1, pc_sel=0 → FETCH. Error or timeout → TRAP, cause 1.
- TRAP: all strobes/enables 0; o_trap=1, cause held until i_rst.
- Every output is 0 outside the states where it is specified; no X outputs.

## Timing
- Enables and selects are Moore (decoded from state and i_instr). o_pc_sel for branches is Mealy on i_alu_zf. o_ir_w_en/o_reg_w_en in FETCH/MEM are Mealy on i_bus_ack.
- Zero-wait bus: ack in the first request cycle completes the transfer. Requests stay high until ack; never deasserted early.
- Latency with zero wait states: ALU/jump/branch 3 cycles, load/store 4. Each bus wait cycle adds 1.
- Timeout: counter clears on entry to FETCH/MEM and increments each un-acked cycle. Trap fires in the cycle the count reaches BUS_TIMEOUT without ack. Ack in that same cycle wins.
- Reset mid-operation: next cycle in FETCH with all enables 0; any pending request is dropped.

## Structure
- ctrl_pkg: state enum, ALU op localparams (ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001), opcode constants, wb/pc select encodings, trap cause codes.
- Sub-module ctrl_dec: combinational opcode/funct decode producing ALU controls, class flags and illegal flag. The FSM, timeout counter and trap register live in ctrl_mc.

## Test plan
- ADDI x1,x0,5 (0x00500093), ack in first cycle → o_ir_w_en at cycle 1, reg_w_en with wb_sel 0 and pc_w_en with pc_sel 0 at cycle 3.
- BEQ with zf=1 → EXEC asserts pc_w_en, pc_sel=2; with zf=0 → pc_sel=0.
- LW, i_addr_lo=00, ack after 3 wait cycles → bus_r_en high 4 cycles, fmt 010, reg_w_en with wb_sel 1 on ack cycle.
- SW with i_addr_lo=10 → TRAP, cause 2, no bus_w_en ever asserted.
- Fetch never acked, BUS_TIMEOUT=4 → o_trap=1, cause 1 after 4 request cycles; stays until reset.
- Instruction 0x00000000 → TRAP, cause 0; i_rst during a MEM wait → next cycle FETCH, outputs 0.
